mc_control_fsm: RTL

Multi-cycle successor to the single-cycle main control decoder. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, using one shared memory port and one shared ALU. It adds a variable-latency memory handshake, a timeout, correct beq/bne resolution and illegal-opcode handling. It sits between the instruction register (opcode/funct) and the multi-cycle datapath muxes and enables.

---
 rtl/mc_control_fsm.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle main control unit. A Moore FSM sequences FETCH, DECODE, EXECUTE,
// MEMORY and WRITEBACK over several cycles, sharing one memory port and one
// ALU. It also handles a variable-latency memory handshake with an optional
// timeout, branch resolution for beq/bne, and unknown opcodes.
//
// Build option:
//   MC_ILLEGAL_TRAP_EN  defined   : an unknown opcode in DECODE sets o_illegal
//                                   and parks the FSM in TRAP.
//                       undefined : an unknown opcode is a NOP, and DECODE
//                                   returns to FETCH without any write.
//
// Parameters:
//   ALUOP_W     width of o_alu_op (>= 4); the 4-bit codes are zero-extended
//   MEM_TIMEOUT max mem_ready-low cycles in a wait state before TRAP (0 = off)
//   TO_CNT_W    wait counter width, 2**TO_CNT_W > MEM_TIMEOUT
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_opcode, i_funct  IR[31:26] / IR[5:0]
//   i_zero             ALU zero flag (same cycle)
//   i_mem_ready        memory access completes this cycle
//   o_iord             0 = PC address, 1 = ALUOut address
//   o_mem_read/write   memory strobes
//   o_ir_write         load IR
//   o_reg_dst          1 = rd, 0 = rt
//   o_mem_to_reg       1 = MDR, 0 = ALUOut
//   o_reg_write        register file write
//   o_alu_src_a        0 = PC, 1 = A
//   o_alu_src_b        00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   o_alu_op           ALU function code
//   o_pc_src           00 = ALU result, 01 = ALUOut, 10 = jump target
//   o_pc_write         PC load (branch-qualified)
//   o_mem_err          sticky memory-timeout flag
//   o_illegal          sticky illegal-opcode flag
//   o_state_dbg        current state encoding
// -----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_CNT_W    = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic               i_zero,
  input  logic               i_mem_ready,
  output logic               o_iord,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ir_write,
  output logic               o_reg_dst,
  output logic               o_mem_to_reg,
  output logic               o_reg_write,
  output logic               o_alu_src_a,
  output logic [1:0]         o_alu_src_b,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [1:0]         o_pc_src,
  output logic               o_pc_write,
  output logic               o_mem_err,
  output logic               o_illegal,
  output logic [3:0]         o_state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_BEQ = 4'd14;
  localparam logic [3:0] ALU_BNE = 4'd15;

  // Counter value seen during the last permitted wait cycle: the timeout
  // fires on the MEM_TIMEOUT-th consecutive mem_ready-low cycle.
  localparam logic [TO_CNT_W-1:0] LP_TO_LAST =
    TO_CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  state_t               r_state;
  state_t               w_next;
  logic [TO_CNT_W-1:0]  r_wait_cnt;
  logic [TO_CNT_W-1:0]  w_wait_cnt_nxt;
  logic                 r_mem_err;
  logic                 r_illegal;
  logic                 w_set_mem_err;
  logic                 w_set_illegal;
  logic                 w_timeout;

  logic                 w_iord;
  logic                 w_mem_read;
  logic                 w_mem_write;
  logic                 w_ir_write;
  logic                 w_reg_dst;
  logic                 w_mem_to_reg;
  logic                 w_reg_write;
  logic                 w_alu_src_a;
  logic [1:0]           w_alu_src_b;
  logic [3:0]           w_alu_code;
  logic [1:0]           w_pc_src;
  logic                 w_pc_write;

  function automatic logic [3:0] f_funct_to_alu(input logic [5:0] funct);
    logic [3:0] code;
    case (funct)
      6'b100000: code = 4'd0;   // add
      6'b100010: code = 4'd1;   // sub
      6'b011000: code = 4'd2;   // mul
      6'b011010: code = 4'd3;   // div
      6'b100100: code = 4'd4;   // and
      6'b100101: code = 4'd5;   // or
      6'b100110: code = 4'd6;   // xor
      6'b100111: code = 4'd7;   // nor
      6'b101000: code = 4'd8;   // nand
      6'b101010: code = 4'd9;   // xnor
      6'b000000: code = 4'd10;  // sll
      6'b000010: code = 4'd11;  // srl
      6'b111000: code = 4'd12;  // rol
      6'b110000: code = 4'd13;  // ror
      default:   code = ALU_ADD;
    endcase
    return code;
  endfunction

  assign w_timeout = (MEM_TIMEOUT != 0) && !i_mem_ready &&
                     (r_wait_cnt == LP_TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_set_mem_err) r_mem_err <= 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nxt = '0;
    w_set_mem_err  = 1'b0;
    w_set_illegal  = 1'b0;
    w_iord         = 1'b0;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_reg_dst      = 1'b0;
    w_mem_to_reg   = 1'b0;
    w_reg_write    = 1'b0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 2'b00;
    w_alu_code     = ALU_ADD;
    w_pc_src       = 2'b00;
    w_pc_write     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (i_mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_set_mem_err = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end

      // Branch target is computed here into ALUOut while the opcode settles.
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (i_opcode)
          6'b000000:            w_next = S_EXEC;
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000100, 6'b000101: w_next = S_BRANCH;
          6'b001000:            w_next = S_ADDIEX;
          6'b000010:            w_next = S_JUMP;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            w_set_illegal = 1'b1;
            w_next        = S_TRAP;
`else
            w_next        = S_FETCH;
`endif
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        // opcode[3] separates sw (101011) from lw (100011)
        w_next      = i_opcode[3] ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_timeout) begin
          w_set_mem_err = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end

      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end

      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (i_mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_set_mem_err = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end

      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_code  = f_funct_to_alu(i_funct);
        w_next      = S_ALUWB;
      end

      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      // opcode[0] separates bne (000101) from beq (000100).
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_code  = i_opcode[0] ? ALU_BNE : ALU_BEQ;
        w_pc_src    = 2'b01;
        w_pc_write  = i_opcode[0] ? !i_zero : i_zero;
        w_next      = S_FETCH;
      end

      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDIWB;
      end

      S_ADDIWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end

      S_JUMP: begin
        w_pc_src   = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
      end

      S_TRAP: w_next = S_TRAP;

      default: w_next = S_FETCH;
    endcase
  end

  // Reset gates every control output combinationally so that an in-flight
  // write strobe drops the moment rst_n falls, not at the next clock edge.
  assign o_iord       = i_rst_n & w_iord;
  assign o_mem_read   = i_rst_n & w_mem_read;
  assign o_mem_write  = i_rst_n & w_mem_write;
  assign o_ir_write   = i_rst_n & w_ir_write;
  assign o_reg_dst    = i_rst_n & w_reg_dst;
  assign o_mem_to_reg = i_rst_n & w_mem_to_reg;
  assign o_reg_write  = i_rst_n & w_reg_write;
  assign o_alu_src_a  = i_rst_n & w_alu_src_a;
  assign o_alu_src_b  = i_rst_n ? w_alu_src_b : 2'b00;
  assign o_alu_op     = i_rst_n ? ALUOP_W'(w_alu_code) : '0;
  assign o_pc_src     = i_rst_n ? w_pc_src : 2'b00;
  assign o_pc_write   = i_rst_n & w_pc_write;
  assign o_mem_err    = r_mem_err;
  assign o_illegal    = r_illegal;
  assign o_state_dbg  = r_state;

endmodule
